// File: rtl/rxpy_seq_param_pkg.sv
// Shared types and constants for the parametrised RX payload sequencer.
package rxpy_seq_param_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rxpy_state_e;

  localparam int HDR_LLID_OFS  = 0;
  localparam int HDR_FLOW_OFS  = 2;
  localparam int HDR_LEN_OFS   = 3;

  localparam int CRC_BITS      = 16;
  localparam int FEC_DATA_BITS = 10;
  localparam int FEC_BLK_LEN   = 15;

endpackage

// File: rtl/rxpy_hdr_extract.sv
// Payload header extractor: captures LLID/FLOW/LENGTH from the decoded bit
// stream, clamps the length and flags lengths beyond the programmed size.
module rxpy_hdr_extract
  import rxpy_seq_param_pkg::*;
#(
  parameter int LENW        = 13,
  parameter int HDR_SS_BITS = 8,
  parameter int HDR_MS_BITS = 16,
  parameter int MAX_BYTES   = 1021
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            start,
  input  logic            run,
  input  logic            brss,
  input  logic            existpyheader,
  input  logic [LENW-1:0] rxpybitlen,
  input  logic            dec_bit,
  input  logic            dec_bit_valid,
  output logic            hdr_valid_p,
  output logic [1:0]      dec_LLID,
  output logic            dec_FLOW,
  output logic [9:0]      dec_pylenByte,
  output logic [LENW-1:0] dec_pylenbit,
  output logic            len_err
);

  localparam int CW          = $clog2(HDR_MS_BITS + 1);
  localparam int LEN_FIELD_W = 10;

  function automatic logic [LENW-1:0] clamp_bits(input logic [9:0] nbyte);
    logic [9:0] sat;
    sat = (int'(nbyte) > MAX_BYTES) ? 10'(MAX_BYTES) : nbyte;
    return LENW'({sat, 3'b000});
  endfunction

  logic          hdr_en_q;
  logic          brss_q;
  logic [CW-1:0] dcnt_q;
  logic [CW-1:0] nbits;
  logic [1:0]    llid_sh, llid_nx;
  logic          flow_sh, flow_nx;
  logic [9:0]    len_sh, len_nx;
  logic          take;
  logic          last_bit;

  // Bits past the LENGTH field still advance the counter but land nowhere.
  always_comb begin
    nbits    = brss_q ? CW'(HDR_SS_BITS) : CW'(HDR_MS_BITS);
    take     = run & dec_bit_valid & hdr_en_q & (dcnt_q < nbits);
    last_bit = take & (dcnt_q == nbits - CW'(1));
    llid_nx  = llid_sh;
    flow_nx  = flow_sh;
    len_nx   = len_sh;
    if (take) begin
      for (int i = 0; i < 2; i++)
        if (int'(dcnt_q) == HDR_LLID_OFS + i) llid_nx[i] = dec_bit;
      if (int'(dcnt_q) == HDR_FLOW_OFS) flow_nx = dec_bit;
      for (int i = 0; i < LEN_FIELD_W; i++)
        if (int'(dcnt_q) == HDR_LEN_OFS + i) len_nx[i] = dec_bit;
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      hdr_en_q      <= 1'b0;
      brss_q        <= 1'b0;
      dcnt_q        <= '0;
      llid_sh       <= '0;
      flow_sh       <= 1'b0;
      len_sh        <= '0;
      hdr_valid_p   <= 1'b0;
      dec_LLID      <= '0;
      dec_FLOW      <= 1'b0;
      dec_pylenByte <= '0;
      dec_pylenbit  <= '0;
      len_err       <= 1'b0;
    end else begin
      hdr_valid_p <= last_bit;
      if (start) begin
        hdr_en_q <= existpyheader;
        brss_q   <= brss;
        dcnt_q   <= '0;
        llid_sh  <= '0;
        flow_sh  <= 1'b0;
        len_sh   <= '0;
        len_err  <= 1'b0;
      end else if (take) begin
        dcnt_q  <= dcnt_q + CW'(1);
        llid_sh <= llid_nx;
        flow_sh <= flow_nx;
        len_sh  <= len_nx;
        if (last_bit) begin
          dec_LLID      <= llid_nx;
          dec_FLOW      <= flow_nx;
          dec_pylenByte <= len_nx;
          dec_pylenbit  <= clamp_bits(len_nx);
          len_err       <= (clamp_bits(len_nx) > rxpybitlen);
        end
      end
    end
  end

endmodule

// File: rtl/rxpy_seq_param.sv
// RX payload bit sequencer: symbol strobe, payload/CRC/FEC windows and end
// pulses. FEC 2/3 block framing is built only when RXPY_FEC23_EN is defined.
module rxpy_seq_param
  import rxpy_seq_param_pkg::*;
#(
  parameter int LENW        = 13,
  parameter int HDR_SS_BITS = 8,
  parameter int HDR_MS_BITS = 16,
  parameter int MAX_BYTES   = 1021
) (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            p_1us,
  input  logic            p_05us,
  input  logic            p_033us,
  input  logic            py_st_p,
  input  logic            packet_BRmode,
  input  logic            packet_DPSK,
  input  logic            fec23_en,
  input  logic            crcencode,
  input  logic            existpyheader,
  input  logic            BRss,
  input  logic [LENW-1:0] rxpybitlen,
  input  logic            dec_bit,
  input  logic            dec_bit_valid,
  output logic            sym_p,
  output logic            py_period,
  output logic            daten,
  output logic            fec_en,
  output logic            crc_period,
  output logic            blk_endp,
  output logic            py_endp,
  output logic            hdr_valid_p,
  output logic [1:0]      dec_LLID,
  output logic            dec_FLOW,
  output logic [9:0]      dec_pylenByte,
  output logic [LENW-1:0] dec_pylenbit,
  output logic            len_err
);

  localparam logic [LENW:0] CRC_W   = (LENW+1)'(CRC_BITS);
  localparam logic [LENW:0] CNT_ONE = (LENW+1)'(1);

  rxpy_state_e   state_q, state_d;
  logic          br_q, dpsk_q, crc_q;
  logic [LENW:0] bit_cnt_q;
  logic [LENW:0] len_ext, tdata;
  logic          run, accept, last_sym;

  assign run     = (state_q == ST_RUN);
  assign accept  = (state_q == ST_IDLE) & py_st_p & (rxpybitlen != '0);
  assign len_ext = {1'b0, rxpybitlen};
  assign tdata   = len_ext + (crc_q ? CRC_W : '0);

  always_comb begin
    if (run) sym_p = br_q ? p_1us : (dpsk_q ? p_05us : p_033us);
    else     sym_p = packet_BRmode ? p_1us : (packet_DPSK ? p_05us : p_033us);
  end

`ifdef RXPY_FEC23_EN
  logic       fec_q;
  logic [3:0] blk_cnt_q;
  logic       blk_last;

  // With FEC the last symbol is the final parity bit of the block whose
  // data slots cover the whole payload (padding included).
  assign blk_last = (blk_cnt_q == 4'(FEC_BLK_LEN - 1));
  assign daten    = run & (~fec_q | (blk_cnt_q < 4'(FEC_DATA_BITS)));
  assign fec_en   = run & fec_q & (blk_cnt_q >= 4'(FEC_DATA_BITS));
  assign blk_endp = run & fec_q & sym_p & blk_last;
  assign last_sym = fec_q ? (blk_last & (bit_cnt_q >= tdata))
                          : (bit_cnt_q == tdata - CNT_ONE);

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      fec_q     <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      if (accept) fec_q <= fec23_en;
      if (accept | py_endp)
        blk_cnt_q <= '0;
      else if (run & sym_p & fec_q)
        blk_cnt_q <= blk_last ? 4'd0 : blk_cnt_q + 4'd1;
    end
  end
`else
  logic unused_fec23;

  assign unused_fec23 = fec23_en;
  assign daten        = run;
  assign fec_en       = 1'b0;
  assign blk_endp     = 1'b0;
  assign last_sym     = (bit_cnt_q == tdata - CNT_ONE);
`endif

  assign py_period  = run;
  assign py_endp    = run & sym_p & last_sym;
  assign crc_period = run & daten & crc_q & (bit_cnt_q >= len_ext) &
                      (bit_cnt_q < len_ext + CRC_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)  state_d = ST_RUN;
      ST_RUN:  if (py_endp) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q   <= ST_IDLE;
      br_q      <= 1'b0;
      dpsk_q    <= 1'b0;
      crc_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        br_q   <= packet_BRmode;
        dpsk_q <= packet_DPSK;
        crc_q  <= crcencode;
      end
      if (accept | py_endp)
        bit_cnt_q <= '0;
      else if (run & sym_p & daten)
        bit_cnt_q <= bit_cnt_q + CNT_ONE;
    end
  end

  rxpy_hdr_extract #(
    .LENW        (LENW),
    .HDR_SS_BITS (HDR_SS_BITS),
    .HDR_MS_BITS (HDR_MS_BITS),
    .MAX_BYTES   (MAX_BYTES)
  ) u_hdr (
    .clk_6M        (clk_6M),
    .rstz          (rstz),
    .start         (accept),
    .run           (run),
    .brss          (BRss),
    .existpyheader (existpyheader),
    .rxpybitlen    (rxpybitlen),
    .dec_bit       (dec_bit),
    .dec_bit_valid (dec_bit_valid),
    .hdr_valid_p   (hdr_valid_p),
    .dec_LLID      (dec_LLID),
    .dec_FLOW      (dec_FLOW),
    .dec_pylenByte (dec_pylenByte),
    .dec_pylenbit  (dec_pylenbit),
    .len_err       (len_err)
  );

endmodule

// File: tb/tb_rxpy_seq_param.sv
// Randomised bench for rxpy_seq_param against a symbol-position reference
// model; follows RXPY_FEC23_EN to decide whether FEC framing is expected.
module tb_rxpy_seq_param;

  localparam int LENW   = 13;
  localparam int BUDGET = 20000;
`ifdef RXPY_FEC23_EN
  localparam bit FEC_BUILD = 1'b1;
`else
  localparam bit FEC_BUILD = 1'b0;
`endif

  logic            clk_6M = 1'b0;
  logic            rstz;
  logic            p_1us, p_05us, p_033us, py_st_p;
  logic            packet_BRmode, packet_DPSK, fec23_en, crcencode;
  logic            existpyheader, BRss;
  logic [LENW-1:0] rxpybitlen;
  logic            dec_bit, dec_bit_valid;
  logic            sym_p, py_period, daten, fec_en, crc_period, blk_endp, py_endp;
  logic            hdr_valid_p, dec_FLOW, len_err;
  logic [1:0]      dec_LLID;
  logic [9:0]      dec_pylenByte;
  logic [LENW-1:0] dec_pylenbit;

  always #5 clk_6M = ~clk_6M;

  rxpy_seq_param #(
    .LENW(LENW), .HDR_SS_BITS(8), .HDR_MS_BITS(16), .MAX_BYTES(1021)
  ) dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .p_05us(p_05us),
    .p_033us(p_033us), .py_st_p(py_st_p), .packet_BRmode(packet_BRmode),
    .packet_DPSK(packet_DPSK), .fec23_en(fec23_en), .crcencode(crcencode),
    .existpyheader(existpyheader), .BRss(BRss), .rxpybitlen(rxpybitlen),
    .dec_bit(dec_bit), .dec_bit_valid(dec_bit_valid), .sym_p(sym_p),
    .py_period(py_period), .daten(daten), .fec_en(fec_en),
    .crc_period(crc_period), .blk_endp(blk_endp), .py_endp(py_endp),
    .hdr_valid_p(hdr_valid_p), .dec_LLID(dec_LLID), .dec_FLOW(dec_FLOW),
    .dec_pylenByte(dec_pylenByte), .dec_pylenbit(dec_pylenbit), .len_err(len_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet described by symbol index, header by bit list.
  bit          m_run, m_br, m_dp, m_fec, m_crc;
  int          m_s, m_total, m_len;
  bit          m_hen, m_brss, m_hpend;
  int          m_hcnt, m_nbits;
  logic [15:0] m_hword;
  logic [15:0] hdr_src;
  logic [1:0]  e_llid;
  bit          e_flow, e_err;
  int          e_byte, e_bits;

  function automatic bit pick(input bit br, input bit dp);
    return br ? p_1us : (dp ? p_05us : p_033us);
  endfunction

  task automatic model_reset();
    m_run = 0; m_s = 0; m_hpend = 0; m_hcnt = 0; m_hen = 0; m_hword = '0;
    e_llid = '0; e_flow = 0; e_err = 0; e_byte = 0; e_bits = 0;
  endtask

  task automatic do_reset();
    rstz = 1'b0;
    p_1us = 0; p_05us = 0; p_033us = 0; py_st_p = 0;
    dec_bit = 0; dec_bit_valid = 0;
    #2;
    check("rst_sym_p",    32'(sym_p), 0);
    check("rst_py_per",   32'(py_period), 0);
    check("rst_daten",    32'(daten), 0);
    check("rst_fec_en",   32'(fec_en), 0);
    check("rst_crc_per",  32'(crc_period), 0);
    check("rst_blk_endp", 32'(blk_endp), 0);
    check("rst_py_endp",  32'(py_endp), 0);
    check("rst_hdr_vld",  32'(hdr_valid_p), 0);
    check("rst_llid",     32'(dec_LLID), 0);
    check("rst_flow",     32'(dec_FLOW), 0);
    check("rst_lenbyte",  32'(dec_pylenByte), 0);
    check("rst_lenbit",   32'(dec_pylenbit), 0);
    check("rst_len_err",  32'(len_err), 0);
    model_reset();
    @(posedge clk_6M); #1;
    rstz = 1'b1;
  endtask

  task automatic step(input bit st);
    bit sym, de, fe, be, ce, pe, was_run, pend_n;
    int pos, idx, t;
    py_st_p = st;
    p_1us   = ($urandom_range(2) == 0);
    p_05us  = ($urandom_range(2) == 0);
    p_033us = ($urandom_range(2) == 0);
    if (m_run) begin
      packet_BRmode = 1'($urandom); packet_DPSK = 1'($urandom);
      fec23_en = 1'($urandom); crcencode = 1'($urandom);
    end
    dec_bit_valid = ($urandom_range(1) == 0);
    dec_bit = (m_hcnt < 16) ? hdr_src[m_hcnt] : 1'($urandom);
    @(negedge clk_6M);
    sym = m_run ? pick(m_br, m_dp) : pick(packet_BRmode, packet_DPSK);
    pos = m_fec ? (m_s % 15) : 0;
    idx = m_fec ? (m_s / 15) * 10 + pos : m_s;
    de  = m_run && (!m_fec || pos < 10);
    fe  = m_run && m_fec && pos >= 10;
    be  = fe && sym && pos == 14;
    ce  = de && m_crc && idx >= m_len && idx < m_len + 16;
    pe  = m_run && sym && (m_s == m_total - 1);
    check("sym_p",      32'(sym_p), 32'(sym));
    check("py_period",  32'(py_period), 32'(m_run));
    check("daten",      32'(daten), 32'(de));
    check("fec_en",     32'(fec_en), 32'(fe));
    check("blk_endp",   32'(blk_endp), 32'(be));
    check("crc_period", 32'(crc_period), 32'(ce));
    check("py_endp",    32'(py_endp), 32'(pe));
    check("hdr_valid",  32'(hdr_valid_p), 32'(m_hpend));
    check("llid",       32'(dec_LLID), 32'(e_llid));
    check("flow",       32'(dec_FLOW), 32'(e_flow));
    check("lenbyte",    32'(dec_pylenByte), 32'(e_byte));
    check("lenbit",     32'(dec_pylenbit), 32'(e_bits));
    check("len_err",    32'(len_err), 32'(e_err));
    pend_n  = 0;
    was_run = m_run;
    if (m_run && dec_bit_valid && m_hen && m_hcnt < m_nbits) begin
      m_hword[m_hcnt] = dec_bit;
      m_hcnt++;
      if (m_hcnt == m_nbits) begin
        pend_n = 1;
        e_llid = m_hword[1:0];
        e_flow = m_hword[2];
        e_byte = m_brss ? int'(m_hword[7:3]) : int'(m_hword[12:3]);
        e_bits = ((e_byte > 1021) ? 1021 : e_byte) * 8;
        e_err  = (e_bits > m_len);
      end
    end
    m_hpend = pend_n;
    if (m_run && sym) begin
      if (pe) m_run = 0;
      m_s++;
    end
    if (!was_run && st && rxpybitlen != '0) begin
      m_run = 1; m_s = 0;
      m_br = packet_BRmode; m_dp = packet_DPSK;
      m_fec = FEC_BUILD & fec23_en; m_crc = crcencode;
      m_len = int'(rxpybitlen);
      t = m_len + (m_crc ? 16 : 0);
      m_total = m_fec ? ((t + 9) / 10) * 15 : t;
      m_hcnt = 0; m_hword = '0; m_hen = existpyheader; m_brss = BRss;
      m_nbits = BRss ? 8 : 16; e_err = 0;
    end
    @(posedge clk_6M); #1;
  endtask

  task automatic run_pkt(input bit br, input bit dp, input bit fec, input bit crc,
                         input int len, input bit brss, input bit hdr,
                         input logic [15:0] src, input int stop_at);
    int n;
    packet_BRmode = br; packet_DPSK = dp; fec23_en = fec; crcencode = crc;
    rxpybitlen = LENW'(len); BRss = brss; existpyheader = hdr; hdr_src = src;
    step(1'b1);
    n = 0;
    while (m_run && n < BUDGET && !(stop_at >= 0 && m_s == stop_at)) begin
      step($urandom_range(40) == 0);
      n++;
    end
    if (stop_at < 0) begin
      step(1'b0);
      step(1'b0);
      check("pkt_idle", 32'(py_period), 0);
    end
  endtask

  initial begin
    int l;
    packet_BRmode = 0; packet_DPSK = 0; fec23_en = 0; crcencode = 0;
    existpyheader = 0; BRss = 0; rxpybitlen = '0; hdr_src = '0;
    do_reset();

    run_pkt(1, 0, 0, 1, 24, 0, 1, 16'h5a3c, -1);
    run_pkt(1, 0, 1, 0, 24, 1, 1, 16'h1234, -1);

    run_pkt(0, 1, 0, 0, 100, 0, 1, {3'b101, 10'h3ff, 1'b1, 2'b10}, -1);
    check("dir_llid",    32'(dec_LLID), 2);
    check("dir_flow",    32'(dec_FLOW), 1);
    check("dir_lenbyte", 32'(dec_pylenByte), 1023);
    check("dir_lenbit",  32'(dec_pylenbit), 8168);
    check("dir_len_err", 32'(len_err), 1);

    run_pkt(0, 0, 1, 1, 200, 1, 1, {8'ha5, 5'd17, 1'b0, 2'b01}, -1);
    check("ss_lenbyte", 32'(dec_pylenByte), 17);
    check("ss_lenbit",  32'(dec_pylenbit), 136);
    check("ss_len_err", 32'(len_err), 0);

    rxpybitlen = '0;
    step(1'b1);
    repeat (4) step(1'b0);
    check("len0_idle", 32'(py_period), 0);

    run_pkt(1, 0, 1, 1, 30, 0, 1, 16'hbeef, 7);
    do_reset();
    run_pkt(0, 1, 0, 1, 12, 1, 1, 16'h00f3, -1);

    for (int k = 0; k < 25; k++) begin
      l = ($urandom_range(3) == 0) ? int'($urandom_range(300, 1)) : int'($urandom_range(60, 1));
      run_pkt(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), l,
              1'($urandom), ($urandom_range(4) != 0), 16'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
